// File: rtl/branch_ctrl_seq.sv
// Hardwired control sequencer for instruction fetch and the conditional-branch class
// (brzr/brnz/brpl/brmi), including the CON flip-flop that evaluates the branch condition.
module branch_ctrl_seq #(
    parameter int          DATA_W   = 32,
    parameter logic [4:0]  OPC_BR   = 5'b10010,
    parameter bit          MEM_WAIT = 1'b1
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Run,
    input  logic              MemReady,
    input  logic [31:0]       IR,
    input  logic [DATA_W-1:0] BusMuxOut,
    output logic              PCout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              Rout,
    output logic              Cout,
    output logic              MARin,
    output logic              Zin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              IncPC,
    output logic              Read,
    output logic              Gra,
    output logic              CONin,
    output logic              ADD,
    output logic              BranchMet,
    output logic              Done,
    output logic              Illegal,
    output logic [3:0]        dbg_state
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_ERR  = 4'd8;

    logic [3:0] state;
    logic [3:0] state_next;
    logic       con;
    logic       op_ok;
    logic       cond;

    assign op_ok     = (IR[31:27] == OPC_BR);
    assign dbg_state = state;
    assign BranchMet = con;

    // Branch condition selected by C2 = IR[20:19]; bus MSB is the sign bit.
    always_comb begin
        cond = 1'b0;
        case (IR[20:19])
            2'b00:   cond = (BusMuxOut == '0);
            2'b01:   cond = (BusMuxOut != '0);
            2'b10:   cond = ~BusMuxOut[DATA_W-1];
            default: cond = BusMuxOut[DATA_W-1];
        endcase
    end

    // Run is a level, sampled only in IDLE and T6. MemReady acts as the memory's
    // "data valid" and is only looked at while T1 is holding the read strobes.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = Run ? S_T0 : S_IDLE;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = (!MEM_WAIT || MemReady) ? S_T2 : S_T1;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = op_ok ? S_T4 : S_ERR;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = Run ? S_T0 : S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= S_IDLE;
            con   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_T3 && op_ok)
                con <= cond;
        end
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Rout    = 1'b0;
        Cout    = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        CONin   = 1'b0;
        ADD     = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                // A non-branch opcode gets no strobes here; ERR follows.
                Gra   = op_ok;
                Rout  = op_ok;
                CONin = op_ok;
            end
            S_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_T5: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_T6: begin
                Zlowout = 1'b1;
                PCin    = con;
                Done    = 1'b1;
            end
            S_ERR:   Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
